// File: rtl/core_ram_arbiter.sv
// Single-port RAM arbiter between instruction fetch (IF) and load/store (MEM).
// MEM has fixed priority; IF gets the next grant after MAX_WAIT MEM grants made while it waited.
module core_ram_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic        err,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wstrb,
  input  logic [31:0] ram_rdata,
  input  logic        ram_done,
  output logic        owner,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester raises req (level) with stable operands and keeps it
  // until its one-cycle done pulse; req is only sampled in IDLE, so it may be
  // dropped or changed during the DONE cycle that follows every completion.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int            WW       = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
  localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [31:0]   NOP      = 32'h0000_0013;

  logic [1:0]    state;
  logic [WW-1:0] wait_cnt;
  logic [7:0]    tmo_cnt;
  logic          grant_mem;
  logic          grant_if;

  assign dbg_state = state;

  always_comb begin
    grant_mem = mem_req && !(if_req && (wait_cnt >= WAIT_MAX));
    grant_if  = !grant_mem && if_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      tmo_cnt   <= '0;
      if_done   <= 1'b0;
      if_rdata  <= '0;
      mem_done  <= 1'b0;
      mem_rdata <= '0;
      err       <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_wstrb <= '0;
      owner     <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      err      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_mem) begin
            ram_en    <= 1'b1;
            ram_we    <= mem_we;
            ram_addr  <= mem_addr;
            ram_wdata <= mem_wdata;
            ram_wstrb <= mem_wstrb;
            owner     <= 1'b1;
            tmo_cnt   <= '0;
            state     <= S_BUSY;
            if (if_req)
              wait_cnt <= (wait_cnt >= WAIT_MAX) ? WAIT_MAX : wait_cnt + 1'b1;
            else
              wait_cnt <= '0;
          end else if (grant_if) begin
            ram_en    <= 1'b1;
            ram_we    <= 1'b0;
            ram_addr  <= if_addr;
            ram_wdata <= '0;
            ram_wstrb <= '0;
            owner     <= 1'b0;
            tmo_cnt   <= '0;
            state     <= S_BUSY;
            wait_cnt  <= '0;
          end else begin
            wait_cnt <= '0;
          end
        end
        S_BUSY: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          // ram_done takes precedence over a timeout landing in the same cycle
          if (ram_done) begin
            ram_en <= 1'b0;
            state  <= S_DONE;
            if (owner) begin
              mem_done <= 1'b1;
              if (!ram_we) mem_rdata <= ram_rdata;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= ram_rdata;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            ram_en <= 1'b0;
            err    <= 1'b1;
            state  <= S_DONE;
            if (owner) begin
              mem_done <= 1'b1;
              if (!ram_we) mem_rdata <= NOP;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= NOP;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/core_ram_arbiter.md
Name: core_ram_arbiter

Overview:
- Arbitrates the single-port instruction/data RAM between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Owns the RAM enable/address/write lines and sequences one transaction at a time.
- MEM has fixed priority, with an anti-starvation override for IF. A watchdog aborts RAM transactions that hang.

Parameters:
- MAX_WAIT, 4: consecutive MEM grants made while if_req is pending, after which IF wins the next arbitration.
- TIMEOUT, 255: maximum BUSY cycles waiting for ram_done before abort. The counter is 8 bits wide; legal range is 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  IF fetch request; level, held until if_done
- if_addr  in  32  fetch address; word aligned
- if_done  out  1  one-cycle pulse; fetch complete
- if_rdata  out  32  fetched instruction; valid from if_done and held until the next IF completion
- mem_req  in  1  MEM request; level, held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  32  data address
- mem_wdata  in  32  store data
- mem_wstrb  in  4  store byte enables
- mem_done  out  1  one-cycle pulse; access complete
- mem_rdata  out  32  load data; held like if_rdata
- err  out  1  one-cycle pulse, coincident with if_done or mem_done when the access timed out
- ram_en  out  1  RAM transaction enable
- ram_we  out  1  RAM write
- ram_addr  out  32  RAM address
- ram_wdata  out  32  RAM write data
- ram_wstrb  out  4  RAM byte enables
- ram_rdata  in  32  RAM read data; valid with ram_done
- ram_done  in  1  RAM completion pulse
- owner  out  1  0 = IF, 1 = MEM; owner of the current or last transaction

Behaviour:
- All outputs are registered.
- Reset values: every output is 0, state = IDLE, wait_cnt = 0, tmo_cnt = 0. Reset is honoured in any state: an in-flight RAM access is dropped (ram_en falls asynchronously), no done pulse is issued, and the RAM is expected to be reset alongside.
- States: IDLE, BUSY, DONE.
- IDLE, arbitration at the clock edge:
  - If mem_req=1 and not (if_req=1 and wait_cnt>=MAX_WAIT): grant MEM.
  - Else if if_req=1: grant IF.
  - Else stay in IDLE.
- On a grant:
  - Latch the winner's addr/we/wdata/wstrb into the ram_* outputs. For IF: ram_we=0, ram_wstrb=0, ram_wdata=0.
  - Set ram_en=1, owner=winner, tmo_cnt=0, next state BUSY.
  - Latency: request seen at edge N gives ram_en high from edge N.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) on each MEM grant made while if_req=1.
  - Clears on an IF grant, or at any IDLE edge where if_req=0.
- BUSY:
  - ram_* outputs are held stable; new requests are ignored.
  - tmo_cnt increments each cycle.
  - If ram_done=1: ram_en<=0; owner's rdata<=ram_rdata on a read (rdata is unchanged on a store); owner's done<=1; next state DONE.
  - Else if tmo_cnt==TIMEOUT-1: ram_en<=0; owner's done<=1; err<=1; rdata<=32'h0000_0013 (NOP) on a read; next state DONE.
  - If ram_done and the timeout coincide, ram_done wins and err stays 0.
- DONE:
  - Lasts one cycle; the done and err pulses drop.
  - Requests are ignored, giving the requester a cycle to drop or change req.
  - Next state IDLE.
- Minimum spacing between transactions is 3 cycles: IDLE, BUSY, DONE.
- A ram_done arriving in IDLE or DONE is ignored.
- A requester dropping req during BUSY does not abort the access; the done pulse is still issued.
- No address or width checks; addresses pass through unmodified.

Test Plan:
- IF only: if_req=1, if_addr=0x100; RAM returns ram_done plus 0x00500093 two cycles after ram_en -> ram_addr=0x100, ram_we=0; if_done one cycle, if_rdata=0x00500093; err=0; state back to IDLE 1 cycle later.
- Priority: if_req and mem_req rise in the same cycle; mem_we=1, addr=0x2000, wdata=0xDEADBEEF, wstrb=0xF -> MEM served first with ram_we=1 and those values; IF is served after mem_done; if_rdata is unchanged by the store.
- Starvation: if_req held high while mem_req is held high and re-requested after each done -> exactly 4 MEM grants, then 1 IF grant, then wait_cnt=0.
- Timeout: mem load, ram_done never asserted -> ram_en high for exactly 255 cycles; mem_done and err pulse together; mem_rdata=0x00000013.
- Coincidence: ram_done arrives in the last timeout cycle -> normal completion, err=0, rdata taken from ram_rdata.
- Reset mid-BUSY: rst_n low during a MEM access -> all outputs go to 0 immediately; no mem_done; after release, a pending if_req is granted on the first edge.
